// File: rtl/dma_utils_pkg.sv
// Shared types for the DMA job scheduler: FSM states, completion status codes
// and the latched job record.
package dma_utils_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned JOB_ID_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_BUSY,
    ST_ABORT,
    ST_RESP
  } sched_state_e;

  typedef enum logic [1:0] {
    CMP_OK      = 2'd0,
    CMP_ERR     = 2'd1,
    CMP_TIMEOUT = 2'd2
  } cmp_status_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   src;
    logic [ADDR_W-1:0]   dst;
    logic [ADDR_W-1:0]   bytes;
    logic [JOB_ID_W-1:0] id;
  } job_t;

endpackage

// File: rtl/dma_job_scheduler_if.sv
// Requester, DMA-engine and completion signals of the job scheduler.
// master = requesters/engine side, slave = the scheduler.
interface dma_job_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0][31:0] req_src_i;
  logic [NUM_REQ-1:0][31:0] req_dst_i;
  logic [NUM_REQ-1:0][31:0] req_bytes_i;

  logic                     dma_go_o;
  logic [31:0]              dma_src_o;
  logic [31:0]              dma_dst_o;
  logic [31:0]              dma_bytes_o;
  logic                     dma_abort_o;
  logic                     dma_done_i;
  logic                     dma_error_i;

  logic                     cmp_valid_o;
  logic [ID_W-1:0]          cmp_id_o;
  logic [1:0]               cmp_status_o;

  modport master (
    output req_valid_i, req_src_i, req_dst_i, req_bytes_i, dma_done_i, dma_error_i,
    input  req_ready_o, dma_go_o, dma_src_o, dma_dst_o, dma_bytes_o, dma_abort_o,
           cmp_valid_o, cmp_id_o, cmp_status_o
  );

  modport slave (
    input  req_valid_i, req_src_i, req_dst_i, req_bytes_i, dma_done_i, dma_error_i,
    output req_ready_o, dma_go_o, dma_src_o, dma_dst_o, dma_bytes_o, dma_abort_o,
           cmp_valid_o, cmp_id_o, cmp_status_o
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping modulo NUM_REQ.
module dma_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_job_scheduler.sv
// Accepts jobs from NUM_REQ requesters round-robin, launches them on a single
// DMA engine and reports completion. Optional BUSY watchdog: DMA_SCHED_WATCHDOG_EN.
module dma_job_scheduler
  import dma_utils_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WDOG_W  = 16
) (
  input logic                clk,
  input logic                rst,
  dma_job_scheduler_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_W < 2) begin : g_bad_cfg
    $error("dma_job_scheduler: unsupported NUM_REQ or WDOG_W");
  end

  sched_state_e     state;
  job_t             job;
  logic [ID_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  win_id;
  logic             go_q;
  logic             cmp_valid_q;
  logic [ID_W-1:0]  cmp_id_q;
  cmp_status_e      cmp_status_q;

  dma_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (bus.req_valid_i),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    win_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_id = ID_W'(i);
    end
  end

  // Grant is only visible while idle and out of reset.
  assign bus.req_ready_o  = (state == ST_IDLE && rst) ? gnt : '0;
  assign bus.dma_go_o     = go_q;
  assign bus.dma_src_o    = job.src;
  assign bus.dma_dst_o    = job.dst;
  assign bus.dma_bytes_o  = job.bytes;
  assign bus.cmp_valid_o  = cmp_valid_q;
  assign bus.cmp_id_o     = cmp_id_q;
  assign bus.cmp_status_o = cmp_status_q;

`ifdef DMA_SCHED_WATCHDOG_EN
  // Expire at the edge that completes the (2^WDOG_W-1)th BUSY cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST = ~WDOG_W'(1);
  logic [WDOG_W-1:0] wdog;
  logic              abort_q;
  assign bus.dma_abort_o = abort_q;
`else
  assign bus.dma_abort_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      job          <= '0;
      go_q         <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_id_q     <= '0;
      cmp_status_q <= CMP_OK;
`ifdef DMA_SCHED_WATCHDOG_EN
      wdog         <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      go_q        <= 1'b0;
      cmp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.req_valid_i) begin
            job.src   <= bus.req_src_i[win_id];
            job.dst   <= bus.req_dst_i[win_id];
            job.bytes <= bus.req_bytes_i[win_id];
            job.id    <= JOB_ID_W'(win_id);
            // Empty jobs complete immediately without touching the engine.
            if (bus.req_bytes_i[win_id] == '0) begin
              state        <= ST_RESP;
              cmp_valid_q  <= 1'b1;
              cmp_id_q     <= win_id;
              cmp_status_q <= CMP_OK;
            end else begin
              state <= ST_GO;
              go_q  <= 1'b1;
            end
          end
        end
        ST_GO: begin
          state <= ST_BUSY;
`ifdef DMA_SCHED_WATCHDOG_EN
          wdog  <= '0;
`endif
        end
        ST_BUSY: begin
          if (bus.dma_done_i || bus.dma_error_i) begin
            state        <= ST_RESP;
            cmp_valid_q  <= 1'b1;
            cmp_id_q     <= ID_W'(job.id);
            cmp_status_q <= bus.dma_error_i ? CMP_ERR : CMP_OK;
          end
`ifdef DMA_SCHED_WATCHDOG_EN
          else if (wdog == WDOG_LAST) begin
            state   <= ST_ABORT;
            abort_q <= 1'b1;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
`endif
        end
`ifdef DMA_SCHED_WATCHDOG_EN
        ST_ABORT: begin
          if (bus.dma_done_i || bus.dma_error_i) begin
            state        <= ST_RESP;
            abort_q      <= 1'b0;
            cmp_valid_q  <= 1'b1;
            cmp_id_q     <= ID_W'(job.id);
            cmp_status_q <= CMP_TIMEOUT;
          end
        end
`endif
        ST_RESP: begin
          state  <= ST_IDLE;
          rr_ptr <= (32'(job.id) + 32'd1 == NUM_REQ) ? '0 : ID_W'(32'(job.id) + 32'd1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
